// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 16-bit little-endian word count followed by
// little-endian instruction bytes, writes the words to sequential addresses, and holds the core meanwhile.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_written
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // LEN0  | expecting length byte N[7:0]
    // LEN1  | expecting length byte N[15:8]; decides DONE / ERR / DATA
    // DATA  | assembling words from bytes, one write per completed word
    // FLUSH | last word's write strobe is out; input closed
    // DONE  | image loaded, core released
    // ERR   | length exceeded DEPTH, core held
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES - 1);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [2:0]            state;
    logic [7:0]            n_lo;
    logic [15:0]           n_len;
    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-1:0] shreg;

    logic                  accept;
    logic [15:0]           len_full;
    logic [DATA_WIDTH+7:0] cat;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  last_word;

    assign s_ready  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    assign cpu_hold = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);

    assign accept    = s_valid && s_ready;
    assign len_full  = {s_data, n_lo};
    // New byte enters at the top and shifts down, so the first byte ends in bits [7:0].
    assign cat       = {s_data, shreg};
    assign word_next = cat[DATA_WIDTH+7:8];
    assign last_word = (words_written == (n_len - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            n_lo          <= '0;
            n_len         <= '0;
            lane          <= '0;
            shreg         <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state         <= S_LEN0;
                        lane          <= '0;
                        shreg         <= '0;
                        mem_addr      <= '0;
                        words_written <= '0;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        n_lo  <= s_data;
                        state <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        n_len <= len_full;
                        if (len_full == 16'd0)
                            state <= S_DONE;
                        else if ({1'b0, len_full} > DEPTH_L)
                            state <= S_ERR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shreg <= word_next;
                        if (lane == LANE_LAST) begin
                            lane          <= '0;
                            mem_we        <= 1'b1;
                            mem_addr      <= words_written[ADDR_W-1:0];
                            mem_wdata     <= word_next;
                            words_written <= words_written + 16'd1;
                            if (last_word)
                                state <= S_FLUSH;
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                S_FLUSH: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed sessions with random images, checked against
// an image-level model of which words should land at which addresses.
module tb_imem_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [15:0]   words_written;

    imem_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_n    = 0;
    int last_cyc = -100;
    int wr_idx   = 0;
    int exp_n    = 0;
    logic [31:0] img      [0:DEPTH-1];
    logic [31:0] exp_data [0:DEPTH-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must hit the next sequential address with the next
    // image word, one cycle after the byte that completed it.
    always @(negedge clk) begin
        cyc++;
        if (rst || (start && !s_ready)) begin
            acc_n  = 0;
            wr_idx = 0;
        end else begin
            if (mem_we) begin
                chk("wr_addr", 32'(mem_addr), 32'(wr_idx));
                if (wr_idx < exp_n) chk("wr_data", mem_wdata, exp_data[wr_idx]);
                chk("wr_latency", 32'(cyc), 32'(last_cyc + 1));
                wr_idx++;
            end
            if (s_valid && s_ready) begin
                if (acc_n >= 2 && ((acc_n - 2) % 4) == 3) last_cyc = cyc;
                acc_n++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_data  = b;
        s_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        if (k == 50) chk("accept_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic run_session(input int n, input bit gaps, input bit noise);
        bit ok_len;
        ok_len = (n <= DEPTH);
        exp_n  = ok_len ? n : 0;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = img[i];
        pulse_start();
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(error), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'(n), gaps);
        send_byte(8'(n >> 8), gaps);
        if (ok_len) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(8'(img[i] >> (8 * k)), gaps);
                    if (noise && i == 0 && k == 1) pulse_start();
                end
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || error) break;
        end
        chk("end_done", 32'(done), ok_len ? 32'd1 : 32'd0);
        chk("end_error", 32'(error), ok_len ? 32'd0 : 32'd1);
        chk("end_hold", 32'(cpu_hold), ok_len ? 32'd0 : 32'd1);
        chk("end_s_ready", 32'(s_ready), 32'd0);
        chk("end_mem_we", 32'(mem_we), 32'd0);
        chk("end_words_written", 32'(words_written), 32'(exp_n));
        chk("end_write_count", 32'(wr_idx), 32'(exp_n));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words_written"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Bytes offered with no start must be refused.
        s_valid = 1'b1; s_data = 8'hA5;
        repeat (5) begin
            @(negedge clk);
            chk("idle_s_ready", 32'(s_ready), 32'd0);
            chk("idle_mem_we", 32'(mem_we), 32'd0);
        end
        chk("idle_hold", 32'(cpu_hold), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;

        img[0] = 32'h00500513;
        run_session(1, 1'b0, 1'b0);

        img[0] = 32'h00000093; img[1] = 32'h00100113; img[2] = 32'hFFDFF06F;
        run_session(3, 1'b1, 1'b0);

        run_session(0, 1'b1, 1'b0);
        run_session(DEPTH + 1, 1'b0, 1'b0);

        repeat (3) begin
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_session(n, 1'b1, 1'b0);
        end

        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        t0 = cyc;
        run_session(DEPTH, 1'b0, 1'b0);
        chk("full_image_no_stall", 32'((cyc - t0) <= 4 * DEPTH + 12), 32'd1);

        // Reset two bytes into the first word; the next session must start aligned.
        img[0] = $urandom; img[1] = $urandom;
        exp_n = 0;
        pulse_start();
        send_byte(8'd2, 1'b0);
        send_byte(8'd0, 1'b0);
        send_byte(img[0][7:0], 1'b0);
        send_byte(img[0][15:8], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        img[0] = $urandom;
        run_session(1, 1'b1, 1'b0);

        // Restart from DONE, with a stray start pulse inside the first word.
        img[0] = $urandom; img[1] = $urandom;
        run_session(2, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side counterpart to the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It drives the memory write port at sequential addresses and holds the core in reset until the image is fully written. It sits between the host/debug byte link (UART RX or test bench) and the instruction memory.

Parameters:
DATA_WIDTH, 32 (`INSTRUCTION_WIDTH), instruction word width; must be a multiple of 8.
DEPTH, 1024 (`INSTRUCTION_DEPTH), number of words in instruction memory.
ADDR_W, $clog2(DEPTH), memory address width.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  one-cycle pulse that begins a load session.
s_data  input  8  incoming byte.
s_valid  input  1  s_data is valid.
s_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  write strobe to instruction memory.
mem_addr  output  ADDR_W  write word address.
mem_wdata  output  DATA_WIDTH  write word.
cpu_hold  output  1  holds the core in reset while high.
done  output  1  load completed successfully; level.
error  output  1  header length exceeded DEPTH; level.
words_written  output  16  count of words committed this session.

Behaviour:
- One clock domain; reset is synchronous and active-high (rst sampled on posedge clk).
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_written=0. FSM goes to IDLE. Reset mid-session discards all partial state.
- A byte is accepted only when s_valid && s_ready. s_data is ignored otherwise.
- States:
  - IDLE: s_ready=0, cpu_hold=1. On start, go to LEN0, clear the byte lane, address and words_written.
  - LEN0: s_ready=1. Accepted byte is stored as N[7:0]; go to LEN1.
  - LEN1: s_ready=1. Accepted byte is N[15:8].
    - If {byte,N[7:0]}==0, go to DONE.
    - If >DEPTH, go to ERR.
    - Otherwise go to DATA.
  - DATA: s_ready=1. Bytes fill the word little-endian: first byte is bits[7:0], fourth byte is bits[31:24]. A 2-bit lane counter tracks the byte position.
    - On acceptance of the 4th byte: the next cycle has mem_we=1 for exactly one cycle, with mem_addr equal to the current word index and mem_wdata equal to the assembled word.
    - The word index and words_written increment together with that write.
    - After the write of word N-1, go to DONE. s_ready goes low in the cycle after the last byte is accepted.
  - DONE: s_ready=0, done=1, cpu_hold=0. Held until start or rst.
  - ERR: s_ready=0, error=1, cpu_hold=1. No memory writes. Held until start or rst.
- start is honoured only in IDLE, DONE and ERR, and restarts the session (done/error clear the cycle after start). start in LEN0/LEN1/DATA is ignored.
- Write latency: exactly one cycle from 4th-byte acceptance to mem_we. Back-to-back bytes with s_valid held high every cycle sustain one word per 4 cycles with no stall; s_ready is never deasserted mid-DATA.
- N==DEPTH is legal: the last write is at address DEPTH-1 and the address does not wrap.
- Gaps (s_valid low) at any point simply stall the FSM with no timeout.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
- Reset then idle: rst high 2 cycles -> cpu_hold=1, s_ready=0, mem_we=0, done=0. With no start, s_valid bytes are not accepted.
- Single word: start; bytes 01 00 13 05 50 00 -> one mem_we pulse, addr=0, wdata=0x00500513. Then done=1, cpu_hold=0, words_written=1.
- Three words with random s_valid gaps: N=3; words 0x00000093, 0x00100113, 0xFFDFF06F -> writes at addr 0,1,2 with exactly those values, each one cycle after its 4th byte. Then done.
- Zero length: bytes 00 00 -> DONE with no mem_we. Oversize: N=DEPTH+1 (01 04 for 1024+1) -> error=1, cpu_hold=1, s_ready=0, no writes. N=1024 full image -> last write at addr 1023, done=1.
- Reset mid-DATA after 2 of 4 bytes: rst -> all outputs return to reset values. A new session writes addr 0 with a correctly aligned word (no leftover bytes).
- Restart from DONE: start pulse -> done clears, cpu_hold=1, new 2-word image overwrites addr 0-1, words_written=2. start pulses during DATA are ignored with no change in sequence.
